// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM state type and funct decode for alu_ctrl_muldiv.
package alu_ctrl_pkg;

    // ALU control codes
    localparam logic [3:0] CtrlAnd  = 4'b0000;
    localparam logic [3:0] CtrlOr   = 4'b0001;
    localparam logic [3:0] CtrlAdd  = 4'b0010;
    localparam logic [3:0] CtrlSub  = 4'b0110;
    localparam logic [3:0] CtrlSlt  = 4'b0111;
    localparam logic [3:0] CtrlMfhi = 4'b1000;
    localparam logic [3:0] CtrlMflo = 4'b1001;
    localparam logic [3:0] CtrlNor  = 4'b1100;
    localparam logic [3:0] CtrlNop  = 4'b1111;

    // ALUOp classes from the main decoder; 101..111 are R-type
    localparam logic [2:0] AluOpAdd = 3'b000;
    localparam logic [2:0] AluOpSub = 3'b001;
    localparam logic [2:0] AluOpOr  = 3'b010;
    localparam logic [2:0] AluOpSlt = 3'b011;
    localparam logic [2:0] AluOpAnd = 3'b100;

    // funct field values
    localparam logic [5:0] FunctAdd   = 6'b100000;
    localparam logic [5:0] FunctSub   = 6'b100010;
    localparam logic [5:0] FunctAnd   = 6'b100100;
    localparam logic [5:0] FunctOr    = 6'b100101;
    localparam logic [5:0] FunctNor   = 6'b100111;
    localparam logic [5:0] FunctSlt   = 6'b101010;
    localparam logic [5:0] FunctMfhi  = 6'b010000;
    localparam logic [5:0] FunctMflo  = 6'b010010;
    localparam logic [5:0] FunctMult  = 6'b011000;
    localparam logic [5:0] FunctMultu = 6'b011001;
    localparam logic [5:0] FunctDiv   = 6'b011010;
    localparam logic [5:0] FunctDivu  = 6'b011011;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    function automatic logic is_rtype(input logic [2:0] alu_op);
        return alu_op[2] && (alu_op[1:0] != 2'b00);
    endfunction

    // mult/multu/div/divu and unknown functs all map to CtrlNop
    function automatic logic [3:0] funct_ctrl(input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = CtrlNop;
        case (funct)
            FunctAdd:  ctrl = CtrlAdd;
            FunctSub:  ctrl = CtrlSub;
            FunctAnd:  ctrl = CtrlAnd;
            FunctOr:   ctrl = CtrlOr;
            FunctNor:  ctrl = CtrlNor;
            FunctSlt:  ctrl = CtrlSlt;
            FunctMfhi: ctrl = CtrlMfhi;
            FunctMflo: ctrl = CtrlMflo;
            default:   ctrl = CtrlNop;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: magnitude conversion, shift/accumulate registers,
// one shift-add or restoring-subtract step per cycle, and sign fix-up of the result.
// Divider path only exists when ALU_CTRL_DIV_EN is defined.
module muldiv_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_signed_i,
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // b: multiplicand or divisor magnitude; acc: upper half / remainder;
    // sh: multiplier shifting out / dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]   b_q, b_d, acc_q, acc_d, sh_q, sh_d;
    logic                neg_q, neg_d;  // negate product or quotient
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

    assign mag1 = (is_signed_i && src1_i[DATA_W-1]) ? -src1_i : src1_i;
    assign mag2 = (is_signed_i && src2_i[DATA_W-1]) ? -src2_i : src2_i;
    assign sum  = {1'b0, acc_q} + {1'b0, b_q};

`ifdef ALU_CTRL_DIV_EN
    logic              div_q, div_d;
    logic              rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic              dz_q, dz_d;            // divide by zero
    logic [DATA_W-1:0] dvd_q, dvd_d;          // raw dividend for the divide-by-zero result
    logic [DATA_W:0]   rem_sh, diff;

    assign rem_sh = {acc_q, sh_q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, b_q};
`else
    logic unused_is_div;
    assign unused_is_div = is_div_i;
`endif

    // Operand load on start, then one iteration step per RUN cycle
    always_comb begin
        b_d   = b_q;
        acc_d = acc_q;
        sh_d  = sh_q;
        neg_d = neg_q;
`ifdef ALU_CTRL_DIV_EN
        div_d     = div_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        dvd_d     = dvd_q;
`endif
        if (load_i) begin
            acc_d = '0;
            neg_d = is_signed_i && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
`ifdef ALU_CTRL_DIV_EN
            div_d     = is_div_i;
            b_d       = is_div_i ? mag2 : mag1;
            sh_d      = is_div_i ? mag1 : mag2;
            rem_neg_d = is_signed_i && src1_i[DATA_W-1];
            dz_d      = is_div_i && (src2_i == '0);
            dvd_d     = src1_i;
`else
            b_d  = mag1;
            sh_d = mag2;
`endif
        end else if (step_i) begin
`ifdef ALU_CTRL_DIV_EN
            if (div_q) begin
                // Borrow in diff[DATA_W] means the trial subtract failed: restore
                if (!diff[DATA_W]) begin
                    acc_d = diff[DATA_W-1:0];
                    sh_d  = {sh_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[DATA_W-1:0];
                    sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                end
            end else
`endif
            if (sh_q[0]) begin
                {acc_d, sh_d} = {sum, sh_q[DATA_W-1:1]};
            end else begin
                {acc_d, sh_d} = {1'b0, acc_q, sh_q[DATA_W-1:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_q   <= '0;
            acc_q <= '0;
            sh_q  <= '0;
            neg_q <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
            div_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            dvd_q     <= '0;
`endif
        end else begin
            b_q   <= b_d;
            acc_q <= acc_d;
            sh_q  <= sh_d;
            neg_q <= neg_d;
`ifdef ALU_CTRL_DIV_EN
            div_q     <= div_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            dvd_q     <= dvd_d;
`endif
        end
    end

    // Sign-corrected result, consumed by the top on the FIX edge
    always_comb begin
        prod = {acc_q, sh_q};
        if (neg_q) begin
            prod = -prod;
        end
        hi_o = prod[2*DATA_W-1:DATA_W];
        lo_o = prod[DATA_W-1:0];
`ifdef ALU_CTRL_DIV_EN
        if (div_q) begin
            if (dz_q) begin
                lo_o = '1;
                hi_o = dvd_q;
            end else begin
                lo_o = neg_q ? -sh_q : sh_q;
                hi_o = rem_neg_q ? -acc_q : acc_q;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus multi-cycle mult/div sequencer with HI/LO registers.
// Define ALU_CTRL_DIV_EN to enable div/divu; otherwise only mult/multu start the sequencer.
module alu_ctrl_muldiv #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [3:0]        ALUCtrl_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    import alu_ctrl_pkg::*;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, lo_q, hi_res, lo_res;
    logic              done_q;
    logic              is_mul, is_dv, start, load, step, write;

    // Single-cycle ALU control decode
    always_comb begin
        ALUCtrl_o = CtrlNop;
        case (ALUOp_i)
            AluOpAdd: ALUCtrl_o = CtrlAdd;
            AluOpSub: ALUCtrl_o = CtrlSub;
            AluOpOr:  ALUCtrl_o = CtrlOr;
            AluOpSlt: ALUCtrl_o = CtrlSlt;
            AluOpAnd: ALUCtrl_o = CtrlAnd;
            default:  ALUCtrl_o = funct_ctrl(funct_i);
        endcase
    end

    assign is_mul = (funct_i == FunctMult) || (funct_i == FunctMultu);
`ifdef ALU_CTRL_DIV_EN
    assign is_dv  = (funct_i == FunctDiv) || (funct_i == FunctDivu);
`else
    assign is_dv  = 1'b0;
`endif
    assign start = valid_i && is_rtype(ALUOp_i) && (is_mul || is_dv) && (state_q == StIdle);

    // Busy covers RUN/FIX, which also holds any mfhi/mflo until HI/LO are written
    assign stall_o = start || (state_q != StIdle);

    // Sequencer next state: IDLE -> RUN (DATA_W steps) -> FIX (write HI/LO) -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        write   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    load    = 1'b1;
                end
            end
            StRun: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                write   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, counter, HI/LO and done pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= write;
            if (write) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    muldiv_iter #(
        .DATA_W(DATA_W)
    ) u_iter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .step_i     (step),
        .is_signed_i(~funct_i[0]),
        .is_div_i   (is_dv),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .hi_o       (hi_res),
        .lo_o       (lo_res)
    );

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv (DATA_W = 32) with a behavioural reference model.
module tb_alu_ctrl_muldiv;
    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] src1, src2;
    logic [3:0]  ctrl;
    logic        stall, done;
    logic [31:0] hi, lo;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_ctrl_muldiv #(
        .DATA_W(W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .ALUOp_i  (aluop),
        .funct_i  (funct),
        .src1_i   (src1),
        .src2_i   (src2),
        .ALUCtrl_o(ctrl),
        .stall_o  (stall),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    // Reference decode table
    function automatic logic [3:0] exp_ctrl(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'b000: return 4'b0010;
            3'b001: return 4'b0110;
            3'b010: return 4'b0001;
            3'b011: return 4'b0111;
            3'b100: return 4'b0000;
            default: begin
                case (f)
                    6'b100000: return 4'b0010;
                    6'b100010: return 4'b0110;
                    6'b100100: return 4'b0000;
                    6'b100101: return 4'b0001;
                    6'b100111: return 4'b1100;
                    6'b101010: return 4'b0111;
                    6'b010000: return 4'b1000;
                    6'b010010: return 4'b1001;
                    default:   return 4'b1111;
                endcase
            end
        endcase
    endfunction

    // Reference arithmetic using native 64-bit and signed integer operators
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        int          sa, sb;
        sa = a;
        sb = b;
        eh = '0;
        el = '0;
        case (f)
            6'b011000: begin
                p = longint'(sa) * longint'(sb);
                eh = p[63:32];
                el = p[31:0];
            end
            6'b011001: begin
                p = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            6'b011010: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'd0;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Present a start in the current cycle, check the combinational stall, cross the start edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        aluop = 3'b101;
        funct = f;
        src1  = a;
        src2  = b;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_stall: stall=%b expected 1 (funct=%b)", stall, f);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        aluop = 3'b000;
        funct = 6'h00;
        src1  = $urandom;
        src2  = $urandom;
    endtask

    // Wait for done after the start edge; leaves time at the done cycle
    task automatic finish_op(input string name, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ph, input logic [31:0] pl);
        logic [31:0] eh, el;
        int cyc = 0;
        int st  = 0;
        bit stable = 1'b1;
        model(f, a, b, eh, el);
        while (done !== 1'b1 && cyc < 200) begin
            if (stall === 1'b1) st++;
            if (hi !== ph || lo !== pl) stable = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc != W + 1) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, W + 1);
        end
        tests_run++;
        if (st != W + 1) begin
            tests_failed++;
            $display("FAIL %s stall_cycles: got %0d, expected %0d", name, st, W + 1);
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL %s hilo_stable: HI/LO changed before done", name);
        end
        tests_run++;
        if (hi !== eh || lo !== el) begin
            tests_failed++;
            $display("FAIL %s result: a=%h b=%h got HI=%h LO=%h expected HI=%h LO=%h",
                     name, a, b, hi, lo, eh, el);
        end
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s stall_after: stall=%b expected 0", name, stall);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] ph, pl;
        ph = hi;
        pl = lo;
        issue(f, a, b);
        finish_op(name, f, a, b, ph, pl);
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done_pulse: done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        aluop = 3'b000;
        funct = 6'h00;
        src1  = '0;
        src2  = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: HI=%h LO=%h done=%b stall=%b expected all 0",
                     hi, lo, done, stall);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        logic [5:0] fl[13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                              6'b101010, 6'b010000, 6'b010010, 6'b011000, 6'b011001,
                              6'b011010, 6'b011011, 6'b111111};
        logic [2:0] op;
        logic [5:0] f;
        // valid stays low so no edge during the sweep can start an operation
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 3; k++) begin
                op = 3'(i);
                f  = 6'($urandom);
                aluop = op;
                funct = f;
                #1;
                tests_run++;
                if (ctrl !== exp_ctrl(op, f)) begin
                    tests_failed++;
                    $display("FAIL decode_aluop: op=%b funct=%b got %b expected %b",
                             op, f, ctrl, exp_ctrl(op, f));
                end
            end
        end
        for (int i = 0; i < 13; i++) begin
            op = 3'($urandom_range(5, 7));
            if (i % 3 == 0) op = 3'b101;
            aluop = op;
            funct = fl[i];
            #1;
            tests_run++;
            if (ctrl !== exp_ctrl(op, fl[i]) || stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL decode_funct: op=%b funct=%b got ctrl=%b stall=%b expected %b/0",
                         op, fl[i], ctrl, stall, exp_ctrl(op, fl[i]));
            end
        end
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom);
            f  = 6'($urandom);
            aluop = op;
            funct = f;
            #1;
            tests_run++;
            if (ctrl !== exp_ctrl(op, f)) begin
                tests_failed++;
                $display("FAIL decode_random: op=%b funct=%b got %b expected %b",
                         op, f, ctrl, exp_ctrl(op, f));
            end
        end
        @(posedge clk);
        #1;
        // mfhi while idle must not stall
        valid = 1'b1;
        aluop = 3'b101;
        funct = 6'b010000;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_mfhi_stall: stall=%b expected 0", stall);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_op("multu_ffff_x2", 6'b011001, 32'hFFFF_FFFF, 32'h0000_0002);
        tests_run++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL multu_const: HI=%h LO=%h expected 00000001/fffffffe", hi, lo);
        end
        run_op("mult_m7_x3", 6'b011000, 32'hFFFF_FFF9, 32'd3);
        run_op("mult_min_min", 6'b011000, 32'h8000_0000, 32'h8000_0000);
`ifdef ALU_CTRL_DIV_EN
        run_op("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2);
        tests_run++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            tests_failed++;
            $display("FAIL div_const: HI=%h LO=%h expected ffffffff/fffffffd", hi, lo);
        end
        run_op("divu_100_0", 6'b011011, 32'd100, 32'd0);
        run_op("div_m7_0", 6'b011010, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
`endif
    endtask

    task automatic test_div_disabled();
`ifndef ALU_CTRL_DIV_EN
        logic [31:0] ph, pl;
        bit ok = 1'b1;
        ph = hi;
        pl = lo;
        valid = 1'b1;
        aluop = 3'b101;
        funct = 6'b011011;
        src1  = 32'd100;
        src2  = 32'd7;
        #1;
        tests_run++;
        if (stall !== 1'b0 || ctrl !== 4'b1111) begin
            tests_failed++;
            $display("FAIL divu_off_decode: stall=%b ctrl=%b expected 0/1111", stall, ctrl);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || stall !== 1'b0 || hi !== ph || lo !== pl) ok = 1'b0;
        end
        valid = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL divu_off_idle: done=%b stall=%b HI=%h LO=%h expected 0/0/%h/%h",
                     done, stall, hi, lo, ph, pl);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
`ifdef ALU_CTRL_DIV_EN
            f = 6'b011000 | 6'($urandom_range(0, 3));
`else
            f = 6'b011000 | 6'($urandom_range(0, 1));
`endif
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
            run_op("random", f, a, b);
        end
    endtask

    task automatic test_mf_stall();
        logic [31:0] a, b, eh, el;
        int cyc = 0;
        bit held = 1'b1;
        a = $urandom;
        b = $urandom;
        model(6'b011001, a, b, eh, el);
        issue(6'b011001, a, b);
        valid = 1'b1;
        aluop = 3'b101;
        funct = 6'b010010;
        #1;
        while (done !== 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) held = 1'b0;
            @(posedge clk);
            #2;
            cyc++;
        end
        tests_run++;
        if (!held || cyc != W + 1) begin
            tests_failed++;
            $display("FAIL mflo_hold: held=%b cycles=%0d expected 1/%0d", held, cyc, W + 1);
        end
        tests_run++;
        if (stall !== 1'b0 || lo !== el || ctrl !== 4'b1001) begin
            tests_failed++;
            $display("FAIL mflo_release: stall=%b LO=%h ctrl=%b expected 0/%h/1001",
                     stall, lo, ctrl, el);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ph, pl, a, b;
        ph = hi;
        pl = lo;
        a = $urandom;
        b = $urandom;
        issue(6'b011000, a, b);
        finish_op("b2b_first", 6'b011000, a, b, ph, pl);
        ph = hi;
        pl = lo;
        issue(6'b011001, b, a);
        finish_op("b2b_second", 6'b011001, b, a, ph, pl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        run_op("pre_reset", 6'b011001, 32'd5, 32'd7);
`ifdef ALU_CTRL_DIV_EN
        issue(6'b011010, 32'hFFFF_FFF9, 32'd2);
`else
        issue(6'b011000, 32'hFFFF_FFF9, 32'd3);
`endif
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: HI=%h LO=%h done=%b stall=%b expected all 0",
                     hi, lo, done, stall);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL reset_discard: done=%b stall=%b HI=%h LO=%h expected 0/0/0/0",
                     done, stall, hi, lo);
        end
        run_op("after_reset", 6'b011001, 32'd3, 32'd4);
        tests_run++;
        if (lo !== 32'd12 || hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL after_reset_const: HI=%h LO=%h expected 0/0000000c", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_div_disabled();
        test_mf_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

ALU control unit for the R-type/I-type datapath, generalised to a parameterised data width. It adds a multi-cycle multiply/divide sequencer with its own HI/LO registers. ALU control decode stays combinational for single-cycle ops. MULT/MULTU/DIV/DIVU launch an iterative operation that stalls the pipeline until HI/LO are written. Sits between the main decoder (ALUOp) and the ALU/register-file write mux.

## Interface
- `DATA_W`, 32: operand and HI/LO width; must be ≥ 4.
- `CNT_W`, $clog2(DATA_W): iteration counter width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: instruction in decode stage is valid.
- `ALUOp_i` in 3: operation class from the main decoder.
- `funct_i` in 6: instruction funct field.
- `src1_i` in DATA_W: rs operand (dividend / multiplicand).
- `src2_i` in DATA_W: rt operand (divisor / multiplier).
- `ALUCtrl_o` out 4: ALU operation select; combinational.
- `stall_o` out 1: hold PC and the decode stage; combinational.
- `done_o` out 1: one-cycle pulse when HI/LO are written.
- `hi_o` out DATA_W: HI register.
- `lo_o` out DATA_W: LO register.

## Operation
ALUOp decode:
- 000 → 0010 (add).
- 001 → 0110 (sub).
- 010 → 0001 (or).
- 011 → 0111 (slt).
- 100 → 0000 (and).
- 101–111 → decode by funct.

Funct decode:
- 100000 → 0010 (add).
- 100010 → 0110 (sub).
- 100100 → 0000 (and).
- 100101 → 0001 (or).
- 100111 → 1100 (nor).
- 101010 → 0111 (slt).
- 010000 → 1000 (mfhi).
- 010010 → 1001 (mflo).
- 011000 mult, 011001 multu, 011010 div, 011011 divu → 1111 (no ALU op).
- Any other funct → 1111. The output is never X.

Start condition: `valid_i` && R-type ALUOp && funct ∈ {mult, multu, div, divu} && state IDLE. Operands and op are latched on the start cycle.

FSM:
- IDLE → RUN on start; counter loads DATA_W−1.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter decrements; at 0 → FIX.
- FIX: sign correction for signed ops, then HI/LO write and `done_o`=1. → IDLE.

Arithmetic:
- Signed ops operate on magnitudes.
- Product is negated if operand signs differ.
- Quotient is negated if signs differ; remainder takes the dividend's sign.
- mult: {HI,LO} = full 2·DATA_W product.
- div: LO = quotient, HI = remainder.

Boundary cases:
- Divide by zero: LO = all ones, HI = src1.
- Signed overflow (−2^(W−1) / −1): LO = −2^(W−1), HI = 0.
- mult/div arriving while busy: ignored; the decoder holds it via `stall_o`.
- mfhi/mflo while busy: `stall_o` = 1 until HI/LO are valid.
- `valid_i`=0: no start and no stall contribution.

Reset (including mid-operation): state IDLE, counter 0, HI = LO = 0, `done_o` = 0, `stall_o` = 0. Any operation in flight is discarded.

## Timing
- `ALUCtrl_o`: zero latency, purely combinational from `ALUOp_i`/`funct_i`.
- mult/div latency: DATA_W+1 cycles after the start edge. With DATA_W=32: start at edge 0; `done_o` and the new HI/LO are visible after edge 33.
- `stall_o`:
  - high in the start cycle (combinational from the start condition);
  - high through every RUN/FIX cycle;
  - high while mfhi/mflo is decoded and state ≠ IDLE;
  - low in the cycle after FIX.
- A back-to-back mult/div may start in the first IDLE cycle after FIX.
- HI/LO are stable except on the FIX edge or reset.

## Configuration
- `ALU_CTRL_DIV_EN` defined: div/divu are supported as above.
- Undefined: div/divu are not recognised as start ops.
  - They decode to 1111, do not stall, and leave HI/LO untouched.
  - The divider datapath is not synthesised.
  - Multiply and all other behaviour are unchanged.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - ALUCtrl code constants (AND, OR, ADD, SUB, SLT, NOR, MFHI, MFLO, NOP = 1111);
  - funct and ALUOp constants;
  - the FSM state enum (IDLE, RUN, FIX).
- One sub-module, `muldiv_iter`, is natural. It holds the datapath: magnitude conversion, shift/accumulate registers, per-step adder/subtractor, and sign fix. The top level keeps the decode, FSM, counter and stall logic.

## Test plan
- Decode sweep: every ALUOp for 000–100, and every listed funct with ALUOp=101 → codes exactly as tabled. funct 111111 → 1111.
- multu 0xFFFFFFFF × 0x00000002 → after 33 cycles: HI=0x00000001, LO=0xFFFFFFFE, `done_o` pulses once; `stall_o` high for exactly 33 cycles.
- mult −7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 0 → LO=0xFFFFFFFF, HI=100. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mflo issued while a mult is busy → `stall_o` held until `done_o`; the next cycle shows `stall_o`=0 with the new LO.
- Assert `rst_i` at cycle 10 of a div → immediately IDLE, HI=LO=0, no `done_o`. A subsequent multu 3×4 → LO=12.
